// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode encodings and mode field width shared by the LED driver
package led_ctrl_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 3'd3;
  localparam logic [MODE_W-1:0] MODE_PWM     = 3'd4;
endpackage

// File: rtl/led_ch.sv
// led_ch: one LED channel (clk/reset/tick, mode, half_period, duty, trig in; led_o/busy out)
module led_ch
  import led_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PWM_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [MODE_W-1:0] mode,
  input  logic [CNT_W-1:0]  half_period,
  input  logic [PWM_W-1:0]  duty,
  input  logic              trig,
  output logic              led_o,
  output logic              busy
);
  logic [MODE_W-1:0] mode_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, hp_m1;
  logic [PWM_W-1:0]  pc_q, pc_d;
  logic              led_q, led_d, busy_q, busy_d, wrap;
  assign hp_m1 = (half_period == '0) ? '0 : half_period - CNT_W'(1);
  assign wrap  = cnt_q >= hp_m1;
  always_comb begin
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    led_d  = led_q;
    busy_d = busy_q;
    if (mode != mode_q) begin
      cnt_d  = '0;
      pc_d   = '0;
      led_d  = (mode == MODE_ON);
      busy_d = 1'b0;
    end else if (mode == MODE_BLINK && tick) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      led_d = led_q ^ wrap;
    end else if (mode == MODE_ONESHOT && trig) begin
      cnt_d  = '0;
      led_d  = 1'b1;
      busy_d = 1'b1;
    end else if (mode == MODE_ONESHOT && tick && busy_q) begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      led_d  = !wrap;
      busy_d = !wrap;
    end else if (mode == MODE_PWM && tick) begin
      pc_d  = pc_q + PWM_W'(1);
      led_d = pc_q < duty;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_OFF;
      cnt_q  <= '0;
      pc_q   <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= mode;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end
  assign led_o = led_q;
  assign busy  = busy_q;
endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: NUM_CH independent LED channels sliced from packed mode/half_period/duty/trig buses to led_o/busy
module led_blink_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PWM_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [NUM_CH*MODE_W-1:0] mode,
  input  logic [NUM_CH*CNT_W-1:0]  half_period,
  input  logic [NUM_CH*PWM_W-1:0]  duty,
  input  logic [NUM_CH-1:0]        trig,
  output logic [NUM_CH-1:0]        led_o,
  output logic [NUM_CH-1:0]        busy
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_ch #(.CNT_W(CNT_W), .PWM_W(PWM_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .mode       (mode[MODE_W*i +: MODE_W]),
      .half_period(half_period[CNT_W*i +: CNT_W]),
      .duty       (duty[PWM_W*i +: PWM_W]),
      .trig       (trig[i]),
      .led_o      (led_o[i]),
      .busy       (busy[i])
    );
  end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: directed self-checking bench for led_blink_ctrl
module tb_led_blink_ctrl;
  logic        clk = 1'b0;
  logic        reset, tick;
  logic [5:0]  mode;
  logic [63:0] half_period;
  logic [15:0] duty;
  logic [1:0]  trig, led_o, busy;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  led_blink_ctrl #(.NUM_CH(2), .CNT_W(32), .PWM_W(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode), .half_period(half_period),
    .duty(duty), .trig(trig), .led_o(led_o), .busy(busy)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [5:0] m);
    reset = 1'b1;
    trig  = 2'b00;
    tick  = 1'b1;
    mode  = m;
    step;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    logic e;
    reset = 1'b1;
    tick = 1'b1;
    mode = {3'd3, 3'd2};
    half_period = {32'd5, 32'd4};
    duty = 16'd0;
    trig = 2'b10;
    for (int c = 0; c < 3; c++) begin
      step;
      vectors++;
      if ({led_o, busy} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold cyc %0d: led_o=%b busy=%b expected 00/00", c, led_o, busy);
      end
    end
    reset = 1'b0;
    trig = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step;
      e = (((k - 1) / 4) % 2) == 1;
      vectors++;
      if (led_o[0] !== e) begin
        miscompares++;
        $display("FAIL reset_release_blink k=%0d: led_o[0]=%b expected %b", k, led_o[0], e);
      end
      vectors++;
      if ({led_o[1], busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_release_ch1 k=%0d: led_o[1]=%b busy=%b expected 0/00", k, led_o[1], busy);
      end
    end
  endtask
  task automatic test_blink;
    logic [15:0] exp_led;
    exp_led = 16'b1010_0110_0111_0000;
    half_period = {32'd5, 32'd4};
    do_reset({3'd0, 3'd2});
    for (int k = 1; k <= 16; k++) begin
      step;
      vectors++;
      if (led_o[0] !== exp_led[k-1]) begin
        miscompares++;
        $display("FAIL blink k=%0d: led_o[0]=%b expected %b", k, led_o[0], exp_led[k-1]);
      end
      if (k == 7) half_period[31:0] = 32'd2;
      if (k == 13) half_period[31:0] = 32'd0;
    end
  endtask
  task automatic test_oneshot;
    logic e;
    half_period = {32'd5, 32'd4};
    do_reset({3'd3, 3'd0});
    step;
    vectors++;
    if ({led_o[1], busy[1]} !== 2'b00) begin
      miscompares++;
      $display("FAIL oneshot_idle: led_o[1]=%b busy[1]=%b expected 0/0", led_o[1], busy[1]);
    end
    trig = 2'b10;
    for (int j = 0; j <= 6; j++) begin
      step;
      trig = 2'b00;
      e = j < 5;
      vectors++;
      if ({led_o[1], busy[1]} !== {e, e}) begin
        miscompares++;
        $display("FAIL oneshot_pulse j=%0d: led/busy=%b%b expected %b%b", j, led_o[1], busy[1], e, e);
      end
    end
    trig = 2'b10;
    for (int j = 0; j <= 9; j++) begin
      step;
      trig = (j == 2) ? 2'b10 : 2'b00;
      e = j < 8;
      vectors++;
      if ({led_o[1], busy[1]} !== {e, e}) begin
        miscompares++;
        $display("FAIL oneshot_retrig j=%0d: led/busy=%b%b expected %b%b", j, led_o[1], busy[1], e, e);
      end
    end
    trig = 2'b10;
    for (int j = 0; j <= 10; j++) begin
      step;
      trig = (j == 4) ? 2'b10 : 2'b00;
      e = j < 10;
      vectors++;
      if ({led_o[1], busy[1]} !== {e, e}) begin
        miscompares++;
        $display("FAIL oneshot_trig_at_expiry j=%0d: led/busy=%b%b expected %b%b", j, led_o[1], busy[1], e, e);
      end
    end
    reset = 1'b1;
    trig = 2'b10;
    step;
    vectors++;
    if (busy[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL oneshot_trig_in_reset: busy[1]=%b expected 0", busy[1]);
    end
    reset = 1'b0;
    trig = 2'b00;
    step;
    vectors++;
    if ({led_o[1], busy[1]} !== 2'b00) begin
      miscompares++;
      $display("FAIL oneshot_after_reset: led/busy=%b%b expected 00", led_o[1], busy[1]);
    end
  endtask
  task automatic test_pwm;
    int ons;
    duty = {8'd0, 8'd64};
    do_reset({3'd0, 3'd4});
    step;
    vectors++;
    if (led_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL pwm_entry: led_o[0]=%b expected 0", led_o[0]);
    end
    ons = 0;
    for (int k = 2; k <= 257; k++) begin
      step;
      ons += int'(led_o[0]);
      if (k == 65) begin
        vectors++;
        if (led_o[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL pwm_last_on: led_o[0]=%b expected 1", led_o[0]);
        end
      end
      if (k == 66) begin
        vectors++;
        if (led_o[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL pwm_first_off: led_o[0]=%b expected 0", led_o[0]);
        end
      end
    end
    vectors++;
    if (ons != 64) begin
      miscompares++;
      $display("FAIL pwm_duty64: on_count=%0d expected 64", ons);
    end
    duty[7:0] = 8'd0;
    ons = 0;
    for (int k = 0; k < 256; k++) begin
      step;
      ons += int'(led_o[0]);
    end
    vectors++;
    if (ons != 0) begin
      miscompares++;
      $display("FAIL pwm_duty0: on_count=%0d expected 0", ons);
    end
    duty[7:0] = 8'd255;
    ons = 0;
    for (int k = 0; k < 256; k++) begin
      step;
      ons += int'(led_o[0]);
    end
    vectors++;
    if (ons != 255) begin
      miscompares++;
      $display("FAIL pwm_duty255: on_count=%0d expected 255", ons);
    end
  endtask
  task automatic test_tick;
    logic e;
    half_period = {32'd5, 32'd2};
    do_reset({3'd0, 3'd2});
    for (int k = 1; k <= 25; k++) begin
      tick = (k % 4) == 0;
      step;
      e = (k >= 8 && k < 16) || k >= 24;
      vectors++;
      if (led_o[0] !== e) begin
        miscompares++;
        $display("FAIL tick_blink k=%0d: led_o[0]=%b expected %b", k, led_o[0], e);
      end
    end
    tick = 1'b0;
    mode[2:0] = 3'd1;
    step;
    vectors++;
    if (led_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL tick_on_mode: led_o[0]=%b expected 1", led_o[0]);
    end
  endtask
  task automatic test_independence;
    half_period = {32'd5, 32'd4};
    do_reset({3'd3, 3'd2});
    step;
    trig = 2'b10;
    step;
    trig = 2'b00;
    vectors++;
    if ({led_o, busy} !== 4'b1010) begin
      miscompares++;
      $display("FAIL indep_trig: led_o=%b busy=%b expected 10/10", led_o, busy);
    end
    step;
    mode[2:0] = 3'd1;
    step;
    vectors++;
    if ({led_o, busy} !== 4'b1110) begin
      miscompares++;
      $display("FAIL indep_ch0_on: led_o=%b busy=%b expected 11/10", led_o, busy);
    end
    mode[5:3] = 3'd0;
    step;
    vectors++;
    if ({led_o, busy} !== 4'b0100) begin
      miscompares++;
      $display("FAIL indep_ch1_off: led_o=%b busy=%b expected 01/00", led_o, busy);
    end
    mode[2:0] = 3'd7;
    step;
    vectors++;
    if (led_o !== 2'b00) begin
      miscompares++;
      $display("FAIL indep_mode7: led_o=%b expected 00", led_o);
    end
  endtask
  initial begin
    test_reset;
    test_blink;
    test_oneshot;
    test_pwm;
    test_tick;
    test_independence;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
